// File: rtl/serial_word_tx_pkg.sv
// Shared types and defaults for the serial word transmitter.
package serial_word_tx_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-index counter width; a 1-bit word still needs a 1-bit counter.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_word_tx_echo.sv
// Model of the paired receiver register plus end-of-word compare.
// Only instantiated when SERIAL_WORD_TX_ECHO_EN is defined.
module serial_word_tx_echo
    import serial_word_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_r2l_i,
    input  logic             shift_l2r_i,
    input  logic             serial_bit_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             done_set_i,
    output logic [WIDTH-1:0] echo_word_o,
    output logic             echo_match_o
);

    logic [WIDTH-1:0] echo_q, echo_d;
    logic             match_q, match_d;

    // Shift/OR form keeps WIDTH=1 legal without part-selects.
    always_comb begin
        echo_d = echo_q;
        if (shift_r2l_i)
            echo_d = (echo_q << 1) | WIDTH'(serial_bit_i);
        else if (shift_l2r_i)
            echo_d = (echo_q >> 1) | (WIDTH'(serial_bit_i) << (WIDTH - 1));
        match_d = done_set_i && (echo_d == word_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            echo_q  <= '0;
            match_q <= 1'b0;
        end else begin
            echo_q  <= echo_d;
            match_q <= match_d;
        end
    end

    assign echo_word_o  = echo_q;
    assign echo_match_o = match_q;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter driving a serial-load shift register.
// Define SERIAL_WORD_TX_ECHO_EN to add the EchoWord/EchoMatch receiver model.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             DataValid,
    output logic             DataReady,
    input  logic             MsbFirst,
    input  logic             Hold,
    output logic             SerialBit,
    output logic             DoShiftR2L,
    output logic             DoShiftL2R,
    output logic             Busy,
    output logic             Done
`ifdef SERIAL_WORD_TX_ECHO_EN
    ,
    output logic [WIDTH-1:0] EchoWord,
    output logic             EchoMatch
`endif
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             msb_q, msb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sbit_q, sbit_d;
    logic             r2l_q, r2l_d;
    logic             l2r_q, l2r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic accept;
    logic last_bit;

    assign accept   = DataValid && (state_q == ST_IDLE);
    assign last_bit = (cnt_q == LAST);

    function automatic logic pick(input logic [WIDTH-1:0] w, input logic msb,
                                  input logic [CW-1:0] idx);
        return msb ? w[LAST - idx] : w[idx];
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (!Hold && last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so this computes what the next cycle presents:
    // bit 0 is loaded on the accept edge, later bits on non-Hold SHIFT edges.
    always_comb begin
        word_d = word_q;
        msb_d  = msb_q;
        cnt_d  = cnt_q;
        sbit_d = sbit_q;
        r2l_d  = 1'b0;
        l2r_d  = 1'b0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d = DataIn;
                    msb_d  = MsbFirst;
                    cnt_d  = '0;
                    sbit_d = pick(DataIn, MsbFirst, '0);
                    r2l_d  = MsbFirst;
                    l2r_d  = !MsbFirst;
                end
            end
            ST_SHIFT: begin
                if (!Hold && !last_bit) begin
                    cnt_d  = cnt_q + CW'(1);
                    sbit_d = pick(word_q, msb_q, cnt_q + CW'(1));
                    r2l_d  = msb_q;
                    l2r_d  = !msb_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            word_q <= '0;
            msb_q  <= 1'b0;
            cnt_q  <= '0;
            sbit_q <= 1'b0;
            r2l_q  <= 1'b0;
            l2r_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            msb_q  <= msb_d;
            cnt_q  <= cnt_d;
            sbit_q <= sbit_d;
            r2l_q  <= r2l_d;
            l2r_q  <= l2r_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign DataReady  = (state_q == ST_IDLE);
    assign SerialBit  = sbit_q;
    assign DoShiftR2L = r2l_q;
    assign DoShiftL2R = l2r_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

`ifdef SERIAL_WORD_TX_ECHO_EN
    serial_word_tx_echo #(.WIDTH(WIDTH)) u_echo (
        .clk_i        (Clock),
        .rst_i        (Reset),
        .shift_r2l_i  (r2l_q),
        .shift_l2r_i  (l2r_q),
        .serial_bit_i (sbit_q),
        .word_i       (word_q),
        .done_set_i   (done_d),
        .echo_word_o  (EchoWord),
        .echo_match_o (EchoMatch)
    );
`endif

endmodule
